// File: rtl/pulseox_pkg.sv
// Shared encodings for the pulse-oximeter AFE readout path: mode codes,
// diagnostic result codes and the fetch sequencer state set.
package pulseox_pkg;

    localparam logic [1:0] MODE_IDLE   = 2'b00;
    localparam logic [1:0] MODE_DIAG   = 2'b01;
    localparam logic [1:0] MODE_STREAM = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    localparam logic [1:0] DIAG_NONE = 2'b00;
    localparam logic [1:0] DIAG_PASS = 2'b10;
    localparam logic [1:0] DIAG_FAIL = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_FRAME,
        S_DIAG_RD,
        S_DIAG_DONE
    } state_t;

endpackage

// File: rtl/rd_lat_timer.sv
// Read-latency timer: held at zero while start is high, then while en is
// high asserts done every RD_LAT+1 cycles.
module rd_lat_timer #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic en,
    output logic done
);

    localparam int CW = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

    logic [CW-1:0] cnt;

    assign done = en && (cnt == CW'(RD_LAT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= done ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sample_fetch_seq.sv
// AFE readback sequencer: fetches NUM_CH channel words into an atomically
// published frame (valid/ready) and performs the diagnostic-word check.
module sample_fetch_seq
    import pulseox_pkg::*;
#(
    parameter int NUM_CH    = 6,
    parameter int DATA_W    = 22,
    parameter int RAM_W     = 24,
    parameter int ADDR_W    = 3,
    parameter int BASE_ADDR = 0,
    parameter int DIAG_ADDR = 6,
    parameter int DIAG_W    = 14,
    parameter int RD_LAT    = 1
) (
    input  logic                     clk,
    input  logic                     in_reset_n,
    input  logic [1:0]               in_mode,
    input  logic                     in_strm_dn,
    output logic [ADDR_W-1:0]        out_addr,
    input  logic [RAM_W-1:0]         in_rd_data,
    output logic [NUM_CH*DATA_W-1:0] out_ch_data,
    output logic                     out_frame_valid,
    input  logic                     in_frame_ready,
    output logic [7:0]               out_overrun_cnt,
    output logic [DIAG_W-1:0]        out_er_data,
    output logic [1:0]               out_diag_er
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t                     state;
    logic [CH_W-1:0]            ch;
    logic [NUM_CH*DATA_W-1:0]   working;
    logic [NUM_CH*DATA_W-1:0]   frame_next;
    logic                       mode_clr;
    logic                       mode_diag;
    logic                       mode_strm;
    logic                       tmr_en;
    logic                       tmr_done;
    logic                       unused_rd_bits;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign mode_clr  = (in_mode == MODE_IDLE) || (in_mode == MODE_RSVD);
    assign mode_diag = (in_mode == MODE_DIAG);
    assign mode_strm = (in_mode == MODE_STREAM);

    // Timer is released only in the states that wait on RAM latency, so it
    // always starts from zero on entry.
    assign tmr_en = (state == S_FETCH) || (state == S_DIAG_RD);

    assign unused_rd_bits = ^in_rd_data;

    rd_lat_timer #(
        .RD_LAT (RD_LAT)
    ) u_timer (
        .clk   (clk),
        .rst_n (in_reset_n),
        .start (!tmr_en),
        .en    (tmr_en),
        .done  (tmr_done)
    );

    // Working frame with the channel being captured this cycle merged in, so
    // the last channel lands in the published frame on the completion edge.
    always_comb begin
        frame_next = working;
        frame_next[int'(ch)*DATA_W +: DATA_W] = in_rd_data[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state           <= S_IDLE;
            ch              <= '0;
            working         <= '0;
            out_addr        <= '0;
            out_ch_data     <= '0;
            out_frame_valid <= 1'b0;
            out_overrun_cnt <= '0;
            out_er_data     <= '0;
            out_diag_er     <= DIAG_NONE;
        end else if (mode_clr) begin
            state           <= S_IDLE;
            ch              <= '0;
            working         <= '0;
            out_addr        <= '0;
            out_ch_data     <= '0;
            out_frame_valid <= 1'b0;
            out_overrun_cnt <= '0;
            out_er_data     <= '0;
            out_diag_er     <= DIAG_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mode_strm && in_strm_dn) begin
                        out_addr <= ADDR_W'(BASE_ADDR);
                        ch       <= '0;
                        state    <= S_FETCH;
                    end else if (mode_diag) begin
                        out_addr <= ADDR_W'(DIAG_ADDR);
                        state    <= S_DIAG_RD;
                    end
                end
                S_FETCH: begin
                    if (!mode_strm) begin
                        working <= '0;
                        ch      <= '0;
                        state   <= S_IDLE;
                    end else begin
                        if (in_strm_dn) begin
                            out_overrun_cnt <= sat_inc(out_overrun_cnt);
                        end
                        if (tmr_done) begin
                            working  <= frame_next;
                            out_addr <= out_addr + 1'b1;
                            if (ch == CH_W'(NUM_CH - 1)) begin
                                out_ch_data     <= frame_next;
                                out_frame_valid <= 1'b1;
                                ch              <= '0;
                                state           <= S_FRAME;
                            end else begin
                                ch <= ch + 1'b1;
                            end
                        end
                    end
                end
                S_FRAME: begin
                    if (!mode_strm) begin
                        out_frame_valid <= 1'b0;
                        state           <= S_IDLE;
                    end else if (in_frame_ready) begin
                        out_frame_valid <= 1'b0;
                        if (in_strm_dn) begin
                            out_addr <= ADDR_W'(BASE_ADDR);
                            ch       <= '0;
                            state    <= S_FETCH;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (in_strm_dn) begin
                        out_overrun_cnt <= sat_inc(out_overrun_cnt);
                    end
                end
                S_DIAG_RD: begin
                    if (!mode_diag) begin
                        state <= S_IDLE;
                    end else if (tmr_done) begin
                        out_er_data <= in_rd_data[DIAG_W-1:0];
                        out_diag_er <= (in_rd_data[DIAG_W-1:0] == '0) ? DIAG_PASS : DIAG_FAIL;
                        state       <= S_DIAG_DONE;
                    end
                end
                S_DIAG_DONE: begin
                    if (!mode_diag) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
